// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor: diff = a - b, computed LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Operands are captured in parallel on an accepted start. The result is
// published in parallel together with a one-cycle done pulse.
//
// Ports:
//   clk        - clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   start      - operation request, only honoured in IDLE
//   a, b       - minuend / subtrahend, captured on the accepted start edge
//   busy       - high while the serial chain is running
//   done       - one-cycle pulse when diff/borrow_out/overflow update
//   diff       - a - b modulo 2^WIDTH
//   borrow_out - final borrow (unsigned a < b)
//   overflow   - signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_part;
    logic             r_br;
    logic [CW-1:0]    r_count;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_part_next;
    logic             w_last;

    // Full-subtractor cell on the current LSBs plus the stored borrow.
    always_comb begin
        w_x         = r_sa[0];
        w_y         = r_sb[0];
        w_d         = w_x ^ w_y ^ r_br;
        w_br_next   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        // New bit enters at the MSB so that after WIDTH shifts the LSB
        // computed first sits at bit 0.
        w_part_next = {w_d, r_part[WIDTH-1:1]};
        w_last      = (r_count == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_part     <= '0;
            r_br       <= 1'b0;
            r_count    <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_sa    <= a;
                        r_sb    <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_br    <= 1'b0;
                        r_count <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_br    <= w_br_next;
                    r_part  <= w_part_next;
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        // Outputs only move here, so partial results are never visible.
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= w_part_next;
                        borrow_out <= w_br_next;
                        overflow   <= (r_a_msb != r_b_msb) &&
                                      (w_part_next[WIDTH-1] != r_a_msb);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_start  = 0;
    int   n_done   = 0;
    int   busy_run = 0;
    logic [W-1:0] vals [16];

    function automatic exp_t mk(logic [W-1:0] d, logic br, logic ov);
        exp_t e;
        e.d  = d;
        e.br = br;
        e.ov = ov;
        return e;
    endfunction

    // Reference for the sweep: plain modular subtraction and sign rule.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.br = (x < y);
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_borrow"}, borrow_out, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("idle_timeout", 1, 0);
    endtask

    task automatic run_op(logic [W-1:0] x, logic [W-1:0] y, exp_t e);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        q.push_back(e);
        n_start++;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    initial begin
        exp_t e;
        int   k;
        vals = '{8'h00, 8'h01, 8'h02, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE,
                 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h10, 8'h20, 8'h33};
        fork
            // Monitor: pops one expectation per done pulse.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    busy_run = 0;
                end else begin
                    if (busy) busy_run++;
                    if (done) begin
                        n_done++;
                        if (q.size() == 0) begin
                            check("unexpected_done", 1, 0);
                        end else begin
                            e = q.pop_front();
                            check("diff", diff, e.d);
                            check("borrow_out", borrow_out, e.br);
                            check("overflow", overflow, e.ov);
                            check("busy_cycles", busy_run, W);
                        end
                        busy_run = 0;
                    end
                end
            end
            begin
                // Reset state
                repeat (2) @(negedge clk);
                check_zero_outputs("reset");
                rst_n = 1'b1;

                // Directed vectors
                run_op(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0));
                run_op(8'h03, 8'h05, mk(8'hFE, 1'b1, 1'b0));
                run_op(8'h00, 8'h00, mk(8'h00, 1'b0, 1'b0));
                run_op(8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1));
                run_op(8'h7F, 8'hFF, mk(8'h80, 1'b1, 1'b1));

                // start held high; operands change mid-run
                wait_idle();
                a     = 8'h10;
                b     = 8'h01;
                start = 1'b1;
                q.push_back(mk(8'h0F, 1'b0, 1'b0));
                n_start++;
                repeat (3) @(negedge clk);
                a = 8'hAA;
                b = 8'h55;
                k = 0;
                while (!done && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 50) check("held_done_timeout", 1, 0);
                q.push_back(mk(8'h55, 1'b0, 1'b1));
                n_start++;
                @(negedge clk);
                check("held_idle_gap", busy, 0);
                @(negedge clk);
                check("held_restart", busy, 1);
                start = 1'b0;

                // Asynchronous reset in the 4th RUN cycle
                wait_idle();
                a     = 8'h20;
                b     = 8'h10;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_zero_outputs("async_rst");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                run_op(8'h20, 8'h10, mk(8'h10, 1'b0, 1'b0));

                // Boundary-value sweep
                for (int i = 0; i < 16; i++)
                    for (int j = 0; j < 16; j++)
                        run_op(vals[i], vals[j], model(vals[i], vals[j]));

                k = 0;
                while (q.size() != 0 && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                repeat (2) @(negedge clk);
                check("queue_empty", q.size(), 0);
                check("done_count", n_done, n_start);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
